// File: rtl/demux_dispatcher.sv
// Dispatches one input word to the next enabled channel of eight, round-robin.
// Latency: one cycle from input transfer to out_valid.
// Backpressure: in_ready follows ch_ready[sel] while a word is held; a stalled word is never dropped.
module demux_dispatcher #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [7:0]       ch_en,
    input  logic [7:0]       ch_ready,
    output logic [2:0]       sel,
    output logic [7:0]       out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [15:0]      disp_cnt,
    output logic             stall_err
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [2:0]       sel_d;
    logic [2:0]       rr_ptr;
    logic [3:0]       stall_cnt;
    logic [WIDTH-1:0] data_q;
    logic             ch_xfer;
    logic             in_xfer;
    logic [2:0]       base;
    logic [2:0]       pick;
    logic [2:0]       idx;
    logic             found;

    assign ch_xfer  = (state_q == SEND) && ch_ready[sel];
    assign in_ready = !rst && (|ch_en) && ((state_q == IDLE) || ch_ready[sel]);
    assign in_xfer  = in_valid && in_ready;

    // Back-to-back words search from the channel after the one just drained.
    always_comb begin
        base  = ch_xfer ? (sel + 3'd1) : rr_ptr;
        pick  = base;
        found = 1'b0;
        idx   = base;
        for (int k = 0; k < 8; k++) begin
            idx = base + 3'(k);
            if (!found && ch_en[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel;
        case (state_q)
            IDLE: begin
                if (in_xfer) begin
                    state_d = SEND;
                    sel_d   = pick;
                end
            end
            SEND: begin
                if (ch_xfer) begin
                    state_d = in_xfer ? SEND : IDLE;
                    if (in_xfer) begin
                        sel_d = pick;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel     <= 3'd0;
        end else begin
            state_q <= state_d;
            sel     <= sel_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr    <= 3'd0;
            data_q    <= '0;
            disp_cnt  <= 16'd0;
            stall_cnt <= 4'd0;
            stall_err <= 1'b0;
        end else begin
            if (in_xfer) begin
                data_q <= in_data;
            end
            if (ch_xfer) begin
                rr_ptr    <= sel + 3'd1;
                disp_cnt  <= disp_cnt + 16'd1;
                stall_cnt <= 4'd0;
            end else if (state_q == SEND) begin
                if (stall_cnt != 4'd15) begin
                    stall_cnt <= stall_cnt + 4'd1;
                end
                // Flag on the same edge the counter hits 15 so it is visible in the 16th stalled cycle.
                if (stall_cnt >= 4'd14) begin
                    stall_err <= 1'b1;
                end
            end
        end
    end

    assign out_valid = (state_q == SEND) ? (8'd1 << sel) : 8'd0;
    assign out_data  = data_q;

endmodule

// File: doc/demux_dispatcher.md
DEMUX_DISPATCHER -- requirements
Module: demux_dispatcher

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the width in bits of the data word being dispatched.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-004 in_valid  input  1  SHALL indicate that the source is offering in_data.
REQ-005 in_ready  output  1  SHALL indicate that the block accepts in_data this cycle; a transfer occurs when in_valid and in_ready are both 1.
REQ-006 in_data  input  WIDTH  SHALL carry the word to dispatch.
REQ-007 ch_en  input  8  SHALL be the per-channel enable mask; bit i set means channel i may receive words.
REQ-008 ch_ready  input  8  SHALL carry channel i's acceptance in bit i.
REQ-009 sel  output  3  SHALL be the selected channel index, the dispatch control for the 1-to-8 demux.
REQ-010 out_valid  output  8  SHALL be one-hot; it equals (1 << sel) when a word is held, else 0.
REQ-011 out_data  output  WIDTH  SHALL be the held word, broadcast to all channels.
REQ-012 disp_cnt  output  16  SHALL be the count of completed channel transfers.
REQ-013 stall_err  output  1  SHALL be a sticky flag set on excessive channel stall.

Function
REQ-014 FSM SHALL have two states: IDLE (no word held) and SEND (word held, out_valid nonzero).
REQ-015 in_ready SHALL be 1 only when ch_en is nonzero and either the state is IDLE or ch_ready[sel] is 1 in SEND.
REQ-016 On an input transfer, in_data SHALL be registered and sel SHALL be loaded with the first enabled channel found searching circularly from rr_ptr upward (rr_ptr, rr_ptr+1, ..., wrapping 7 to 0); the state then becomes SEND.
REQ-017 ch_en SHALL be sampled only at the input transfer; later changes SHALL NOT alter or abort a held word.
REQ-018 In SEND, a channel transfer occurs when ch_ready[sel] is 1; out_valid, out_data and sel SHALL stay stable until that transfer.
REQ-019 On a channel transfer, rr_ptr SHALL become (sel+1) mod 8 and disp_cnt SHALL increment, wrapping from 0xFFFF to 0.
REQ-020 A channel transfer and an input transfer in the same cycle SHALL stay in SEND with the new word; the new sel is searched from (old sel + 1) mod 8, giving one word per cycle with no bubble.
REQ-021 A channel transfer without an input transfer SHALL return the FSM to IDLE.
REQ-022 Latency SHALL be one cycle: a word accepted in cycle N is presented on out_valid in cycle N+1.
REQ-023 ch_ready bits for unselected channels SHALL be ignored.
REQ-024 A 4-bit stall counter SHALL count consecutive SEND cycles with ch_ready[sel] equal to 0, saturating at 15.
REQ-025 The stall counter SHALL clear on each channel transfer.
REQ-026 stall_err SHALL be set when the stall counter reaches 15 and SHALL clear only on reset; the held word SHALL NOT be dropped.
REQ-027 When ch_en is 0, in_ready SHALL be 0, and any held word SHALL still complete on its channel.

Reset
REQ-028 While rst is 1 at a clock edge: state SHALL go to IDLE, with sel=0, rr_ptr=0, out_valid=0, out_data=0, disp_cnt=0, stall counter=0 and stall_err=0.
REQ-029 A rst asserted during SEND SHALL discard the held word with no channel transfer; in_ready SHALL be 0 while rst is 1.

Verification
REQ-030 Reset with ch_en=FF and ch_ready=FF, then stream 10 words 0x01..0x0A with in_valid held at 1 -> sel sequence 0,1,...,7,0,1; disp_cnt=10; in_ready stays at 1 throughout.
REQ-031 Set ch_en=0x24 and send 3 words -> sel sequence 2,5,2; out_valid sequence 0x04,0x20,0x04.
REQ-032 Hold a word on channel 3 with ch_ready[3]=0 for 20 cycles, then raise it -> out_valid=0x08 stable; stall_err=1 from the 16th SEND cycle; the transfer completes; stall_err remains 1.
REQ-033 Change ch_en from FF to 0x01 while a word is held on channel 6 -> the word completes on channel 6; the next word goes to channel 0.
REQ-034 Assert rst for one cycle mid-SEND -> out_valid=0 and disp_cnt=0 on the next cycle; the next word goes to channel 0.
REQ-035 Set ch_en=0 with in_valid=1 -> in_ready=0; no state change.
